// File: rtl/ahb_mtx_rr_arb.sv
// ahb_mtx_rr_arb
// Round-robin owner selection for one bus-matrix output stage. The granted
// port index and the "nobody granted" flag feed the output-stage mux, whose
// muxed HSEL/HTRANS/HBURST/HMASTLOCK/HREADY come back here.
// Ownership is re-evaluated only on edges where HREADYM=1. A locked sequence
// always keeps the owner.
// Build option: define AHB_ARB_BURST_HOLD_EN to also keep the owner for the
// whole of a fixed-length burst (WRAP/INCR 4, 8, 16). Without it the burst
// state and its beat counter do not exist, and arbitration runs on every
// ready edge outside a lock.
//
// state    | meaning
// ST_ARB   | owner is free to change at the next ready edge
// ST_BURST | fixed-length burst in flight, owner held until the last beat
// ST_LOCK  | locked sequence in flight, owner held while HMASTLOCKM=1
module ahb_mtx_rr_arb #(
  parameter int NUM_PORTS  = 3,
  parameter int BEAT_CNT_W = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [1:0]           addr_in_port,
  output logic                 no_port,
  output logic                 burst_hold
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t     state_q;
  logic [1:0] addr_q;
  logic [1:0] last_ptr_q;
  logic       no_port_q;
  logic       burst_hold_q;

  logic       hi_found, lo_found, pick_found;
  logic [1:0] hi_idx, lo_idx, pick_idx;
  logic       lock_take;

  // A lock can only be taken over by a port that actually owns the bus.
  assign lock_take = HMASTLOCKM && !no_port_q;

`ifdef AHB_ARB_BURST_HOLD_EN
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [BEAT_CNT_W-1:0] burst_beats;
  logic                  xfer_seq, xfer_busy, burst_start;

  assign xfer_seq  = HSELM && (HTRANSM == TR_SEQ);
  assign xfer_busy = HSELM && (HTRANSM == TR_BUSY);
  // Leaving a lock goes straight to selection, so a NONSEQ seen on that edge
  // cannot pin the old lock owner into a burst.
  assign burst_start = HSELM && (HTRANSM == TR_NONSEQ) && (HBURSTM[2:1] != 2'b00)
                       && (state_q != ST_LOCK);

  // SEQ beats still to come after the NONSEQ of a fixed-length burst.
  always_comb begin
    case (HBURSTM[2:1])
      2'b01:   burst_beats = BEAT_CNT_W'(3);
      2'b10:   burst_beats = BEAT_CNT_W'(7);
      2'b11:   burst_beats = BEAT_CNT_W'(15);
      default: burst_beats = '0;
    endcase
  end
`else
  logic                  unused_xfer;
  logic [BEAT_CNT_W-1:0] unused_beat_cnt;
  assign unused_xfer     = ^{HSELM, HTRANSM, HBURSTM};
  assign unused_beat_cnt = '0;
`endif

  // Round-robin pick: first request above the last winner, else first one
  // at or below it, so the current owner ends up with the lowest priority.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = 2'd0;
    lo_idx   = 2'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!hi_found && req_port[i] && (i > int'(last_ptr_q))) begin
        hi_found = 1'b1;
        hi_idx   = 2'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!lo_found && req_port[i] && (i <= int'(last_ptr_q))) begin
        lo_found = 1'b1;
        lo_idx   = 2'(i);
      end
    end
    pick_found = hi_found || lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Ownership FSM with registered grant outputs; everything holds while HREADYM=0.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_ARB;
      addr_q       <= 2'd0;
      no_port_q    <= 1'b1;
      burst_hold_q <= 1'b0;
      last_ptr_q   <= 2'(NUM_PORTS - 1);
`ifdef AHB_ARB_BURST_HOLD_EN
      beat_cnt_q   <= '0;
`endif
    end else if (HREADYM) begin
      if (lock_take) begin
        state_q      <= ST_LOCK;
        burst_hold_q <= 1'b1;
`ifdef AHB_ARB_BURST_HOLD_EN
        beat_cnt_q   <= '0;
`endif
      end
`ifdef AHB_ARB_BURST_HOLD_EN
      else if ((state_q == ST_BURST) && xfer_seq) begin
        beat_cnt_q <= beat_cnt_q - BEAT_CNT_W'(1);
        if (beat_cnt_q == BEAT_CNT_W'(1)) begin
          state_q      <= ST_ARB;
          burst_hold_q <= 1'b0;
        end
      end else if ((state_q == ST_BURST) && xfer_busy) begin
        state_q <= ST_BURST;
      end else if (burst_start) begin
        state_q      <= ST_BURST;
        burst_hold_q <= 1'b1;
        beat_cnt_q   <= burst_beats;
      end
`endif
      else begin
        state_q      <= ST_ARB;
        burst_hold_q <= 1'b0;
`ifdef AHB_ARB_BURST_HOLD_EN
        beat_cnt_q   <= '0;
`endif
        if (pick_found) begin
          addr_q     <= pick_idx;
          last_ptr_q <= pick_idx;
          no_port_q  <= 1'b0;
        end else begin
          no_port_q  <= 1'b1;
        end
      end
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;
  assign burst_hold   = burst_hold_q;

endmodule

// File: tb/tb_ahb_mtx_rr_arb.sv
// Bench for ahb_mtx_rr_arb: directed scenarios with literal expectations,
// then a long randomized run, all compared against a behavioural model.
`timescale 1ns/1ps
module tb_ahb_mtx_rr_arb;
  localparam int NP = 3;
  localparam int M_ARB = 0, M_BURST = 1, M_LOCK = 2;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_INCR8 = 3'b101, B_INCR16 = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] req = '0;
  logic          rdy = 1'b1;
  logic          sel = 1'b0;
  logic [1:0]    trans = T_IDLE;
  logic [2:0]    hb = B_SINGLE;
  logic          lk = 1'b0;
  logic [1:0]    addr;
  logic          nop, bh;

  int n_checks = 0;
  int n_errors = 0;

  // model: who owns the bus, whether anyone does, what kind of hold is active
  int m_owner = 0, m_none = 1, m_mode = M_ARB, m_left = 0, m_last = NP - 1;
  int m_reselect, m_p;
  bit started = 1'b0;

  int e_rr1[4] = '{0, 1, 2, 0};
  int e_rr2[4] = '{2, 0, 2, 0};
  int busy_list[10] = '{2, 3, 1, 3, 1, 3, 3, 3, 3, 3};

  always #5 clk = ~clk;

  ahb_mtx_rr_arb #(.NUM_PORTS(NP), .BEAT_CNT_W(4)) dut (
    .HCLK(clk), .HRESET(rst), .req_port(req), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(trans), .HBURSTM(hb), .HMASTLOCKM(lk),
    .addr_in_port(addr), .no_port(nop), .burst_hold(bh)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input int ea, input int en, input int eb);
    chk({name, "_addr"}, 32'(addr), 32'(ea));
    chk({name, "_no_port"}, 32'(nop), 32'(en));
    chk({name, "_burst_hold"}, 32'(bh), 32'(eb));
  endtask

  // Behavioural reference: ownership rules applied transaction by transaction.
  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_none = 1; m_mode = M_ARB; m_left = 0; m_last = NP - 1;
      started = 1'b1;
    end else if (rdy) begin
      m_reselect = 0;
      if (lk && m_none == 0) begin
        m_mode = M_LOCK;
        m_left = 0;
      end else if (m_mode == M_LOCK) begin
        m_reselect = 1;
      end
`ifdef AHB_ARB_BURST_HOLD_EN
      else if (m_mode == M_BURST && sel && trans == T_SEQ) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = M_ARB;
      end else if (m_mode == M_BURST && sel && trans == T_BUSY) begin
        m_mode = M_BURST;
      end else if (sel && trans == T_NSEQ && int'(hb) >= 2) begin
        m_mode = M_BURST;
        m_left = (4 << ((int'(hb) - 2) / 2)) - 1;
      end
`endif
      else begin
        m_reselect = 1;
      end
      if (m_reselect != 0) begin
        m_mode = M_ARB;
        m_left = 0;
        m_none = 1;
        for (int k = 1; k <= NP; k++) begin
          m_p = (m_last + k) % NP;
          if (m_none == 1 && req[m_p]) begin
            m_none  = 0;
            m_owner = m_p;
          end
        end
        if (m_none == 0) m_last = m_owner;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_addr", 32'(addr), 32'(m_owner));
      chk("cmp_no_port", 32'(nop), 32'(m_none));
      chk("cmp_burst_hold", 32'(bh), 32'(m_mode != M_ARB));
    end
  end

  task automatic step(input logic [NP-1:0] r, input logic [1:0] t, input logic [2:0] b,
                      input logic s, input logic l);
    req = r; trans = t; hb = b; sel = s; lk = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // reset held two cycles with everyone requesting
    step(3'b111, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
    step(3'b111, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
    chk3("reset", 0, 1, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(3'b111, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
      chk3("rr_first", e_rr1[i], 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(3'b101, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
      chk3("rr_fair", e_rr2[i], 0, 0);
    end

    // INCR4 by port 1
    do_reset();
    step(3'b111, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
    step(3'b111, T_NSEQ, B_SINGLE, 1'b1, 1'b0);
    chk3("incr4_setup", 1, 0, 0);
    step(3'b111, T_NSEQ, B_INCR4, 1'b1, 1'b0);
`ifdef AHB_ARB_BURST_HOLD_EN
    chk3("incr4_nseq", 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(3'b111, T_SEQ, B_INCR4, 1'b1, 1'b0);
      chk3("incr4_seq", 1, 0, (i < 2) ? 1 : 0);
    end
    step(3'b111, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    chk3("incr4_next", 2, 0, 0);

    // INCR8 by port 0 with BUSY beats and wait states
    do_reset();
    step(3'b001, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(3'b111, 2'(busy_list[i]), B_INCR8, 1'b1, 1'b0);
      chk3("incr8_beat", 0, 0, (i == 9) ? 0 : 1);
      if (i == 3) begin
        rdy = 1'b0;
        for (int w = 0; w < 3; w++) begin
          step(3'b111, T_IDLE, B_SINGLE, 1'b0, 1'b0);
          chk3("incr8_wait", 0, 0, 1);
        end
        rdy = 1'b1;
      end
    end
    step(3'b111, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    chk3("incr8_next", 1, 0, 0);

    // IDLE two beats into an INCR16
    do_reset();
    step(3'b001, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    step(3'b111, T_NSEQ, B_INCR16, 1'b1, 1'b0);
    chk3("incr16_nseq", 0, 0, 1);
    step(3'b111, T_SEQ, B_INCR16, 1'b1, 1'b0);
    step(3'b111, T_SEQ, B_INCR16, 1'b1, 1'b0);
    chk3("incr16_seq", 0, 0, 1);
    step(3'b111, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    chk3("incr16_early", 1, 0, 0);
`else
    chk3("incr4_nohold", 2, 0, 0);
`endif

    // lock by port 0, including beats with HSELM low
    do_reset();
    step(3'b001, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    chk3("lock_setup", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(3'b110, T_NSEQ, B_SINGLE, (i == 2 || i == 3) ? 1'b0 : 1'b1, 1'b1);
      chk3("lock_hold", 0, 0, 1);
    end
    step(3'b110, T_IDLE, B_SINGLE, 1'b1, 1'b0);
    chk3("lock_release", 1, 0, 0);

    // reset in the middle of a burst
    do_reset();
    step(3'b001, T_IDLE, B_SINGLE, 1'b0, 1'b0);
    step(3'b111, T_NSEQ, B_INCR8, 1'b1, 1'b0);
    rst = 1'b1;
    step(3'b111, T_SEQ, B_INCR8, 1'b1, 1'b0);
    chk3("midburst_rst", 0, 1, 0);
    rst = 1'b0;
    step(3'b111, T_SEQ, B_INCR8, 1'b1, 1'b0);
    chk3("after_rst", 0, 0, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      req = NP'($urandom_range(0, (1 << NP) - 1));
      sel = ($urandom_range(0, 7) != 0);
      r = int'($urandom_range(0, 9));
      trans = (r < 5) ? T_SEQ : (r < 7) ? T_NSEQ : (r < 8) ? T_BUSY : T_IDLE;
      hb = 3'($urandom_range(0, 7));
      if (lk) lk = ($urandom_range(0, 3) != 0);
      else    lk = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
